// File: rtl/phy_sync_pkg.sv
// Shared types and constants for the PHY status-level debounce path.
package phy_sync_pkg;

  // Debounce FSM states: level settled, or a differing level being qualified
  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_QUALIFY = 1'b1
  } phy_dbnc_state_t;

  localparam int         GLITCH_CNT_W   = 8;
  localparam logic [7:0] GLITCH_CNT_MAX = 8'hFF;

endpackage

// File: rtl/phy_sat_counter.sv
// Parameterized-width saturating event counter; clear has priority over increment.
module phy_sat_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

  logic [W-1:0] cnt_q;

  // Count inc events, stick at all-ones, clear wins over a same-cycle increment
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= {W{1'b0}};
    end else if (clr_i) begin
      cnt_q <= {W{1'b0}};
    end else if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + W'(1);
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/phy_sync_debounce.sv
// Glitch filter for a synchronized PHY status level, with rise/fall pulses.
// A new level is accepted only after FILTER_CYCLES consecutive differing
// samples; shorter runs are rejected and counted in glitch_cnt.
// Optional macro PHY_SYNC_DEBOUNCE_GLITCH_CNT_EN: when defined the glitch
// counter and clr_glitch are present; otherwise glitch_cnt reads 8'h00.
module phy_sync_debounce
  import phy_sync_pkg::*;
#(
  parameter logic RESET_VALUE   = 1'b0,
  parameter int   FILTER_CYCLES = 8,
  parameter int   CNT_W         = $clog2(FILTER_CYCLES) + 1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    d_in,
  input  logic                    filter_en,
  input  logic                    clr_glitch,
  output logic                    d_out,
  output logic                    rise_pulse,
  output logic                    fall_pulse,
  output logic [GLITCH_CNT_W-1:0] glitch_cnt
);

  // Count value on the edge that completes qualification
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

  phy_dbnc_state_t  state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             d_out_q;
  logic             rise_q;
  logic             fall_q;
  logic             glitch_evt;

  // A qualifying run ends early when the input returns to the held level
  assign glitch_evt = filter_en & (state_q == ST_QUALIFY) & (d_in == d_out_q);

  // Debounce FSM with qualify counter; level and pulses are registered here
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_STABLE;
      cnt_q   <= {CNT_W{1'b0}};
      d_out_q <= RESET_VALUE;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else if (!filter_en) begin
      // Bypass: follow the input with one cycle of latency, abandon any qualification
      state_q <= ST_STABLE;
      cnt_q   <= {CNT_W{1'b0}};
      d_out_q <= d_in;
      rise_q  <= d_in & ~d_out_q;
      fall_q  <= ~d_in & d_out_q;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      case (state_q)
        ST_STABLE: begin
          if (d_in != d_out_q) begin
            state_q <= ST_QUALIFY;
            cnt_q   <= CNT_W'(1);
          end else begin
            state_q <= ST_STABLE;
            cnt_q   <= {CNT_W{1'b0}};
          end
        end
        ST_QUALIFY: begin
          if (d_in == d_out_q) begin
            state_q <= ST_STABLE;
            cnt_q   <= {CNT_W{1'b0}};
          end else if (cnt_q == CNT_LAST) begin
            state_q <= ST_STABLE;
            cnt_q   <= {CNT_W{1'b0}};
            d_out_q <= d_in;
            rise_q  <= d_in;
            fall_q  <= ~d_in;
          end else begin
            state_q <= ST_QUALIFY;
            cnt_q   <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_STABLE;
          cnt_q   <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign d_out      = d_out_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;

`ifdef PHY_SYNC_DEBOUNCE_GLITCH_CNT_EN
  phy_sat_counter #(
    .W (GLITCH_CNT_W)
  ) u_glitch_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .inc_i   (glitch_evt),
    .clr_i   (clr_glitch),
    .cnt_o   (glitch_cnt)
  );
`else
  // Counter removed: the event and clear inputs have no consumer
  logic unused_glitch_sigs;
  assign unused_glitch_sigs = glitch_evt ^ clr_glitch;
  assign glitch_cnt         = {GLITCH_CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_phy_sync_debounce.sv
// Directed self-checking bench for phy_sync_debounce (FILTER_CYCLES=4).
// Inputs change just after the falling edge; outputs are sampled on the
// following falling edge, i.e. after exactly one rising edge.
module tb_phy_sync_debounce;

`ifdef PHY_SYNC_DEBOUNCE_GLITCH_CNT_EN
  localparam bit GC_EN = 1'b1;
`else
  localparam bit GC_EN = 1'b0;
`endif

  logic       clock;
  logic       reset_n;
  logic       d_in;
  logic       filter_en;
  logic       clr_glitch;
  logic       d_out;
  logic       rise_pulse;
  logic       fall_pulse;
  logic [7:0] glitch_cnt;

  int n_cmp;
  int n_bad;
  int gmod;   // glitch count model (as if the counter were present)

  phy_sync_debounce #(
    .RESET_VALUE   (1'b0),
    .FILTER_CYCLES (4)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .d_in       (d_in),
    .filter_en  (filter_en),
    .clr_glitch (clr_glitch),
    .d_out      (d_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .glitch_cnt (glitch_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance by one rising edge, landing on the next falling edge
  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clock);
  endtask

  function automatic int gexp();
    return GC_EN ? gmod : 0;
  endfunction

  function automatic int gsat(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  task automatic check_out(input string tag, input int eo, input int er, input int ef);
    check({tag, ".d_out"}, d_out, eo);
    check({tag, ".rise"}, rise_pulse, er);
    check({tag, ".fall"}, fall_pulse, ef);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; gmod = 0;
    reset_n = 1'b0; d_in = 1'b0; filter_en = 1'b1; clr_glitch = 1'b0;
    step(2);
    check_out("reset", 0, 0, 0);
    check("reset.gcnt", glitch_cnt, 0);
    reset_n = 1'b1;
    step(2);
    check_out("rel", 0, 0, 0);

    // Clean rise: accepted on the 4th edge, pulse gone on the 5th
    d_in = 1'b1;
    step(3);
    check_out("rise3", 0, 0, 0);
    step(1);
    check_out("rise4", 1, 1, 0);
    step(1);
    check_out("rise5", 1, 0, 0);
    // Clean fall
    d_in = 1'b0;
    step(3);
    check_out("fall3", 1, 0, 0);
    step(1);
    check_out("fall4", 0, 0, 1);
    step(1);
    check_out("fall5", 0, 0, 0);

    // Longest rejected glitch: 3 differing samples
    d_in = 1'b1; step(3);
    d_in = 1'b0; step(1);
    gmod = gsat(gmod);
    check_out("gl1", 0, 0, 0);
    check("gl1.gcnt", glitch_cnt, gexp());

    // 255 more glitches: counter saturates at 255
    for (int k = 0; k < 255; k++) begin
      d_in = 1'b1; step(3);
      check("glN.d_out", d_out, 0);
      d_in = 1'b0; step(1);
      gmod = gsat(gmod);
      check("glN.rise", rise_pulse, 0);
      if (k == 253) check("gl255.gcnt", glitch_cnt, gexp());
    end
    check("glsat.gcnt", glitch_cnt, gexp());
    // One more stays saturated
    d_in = 1'b1; step(2);
    d_in = 1'b0; step(1);
    gmod = gsat(gmod);
    check("glsat2.gcnt", glitch_cnt, gexp());

    // Clear coincident with a glitch event: clear wins
    d_in = 1'b1; step(3);
    d_in = 1'b0; clr_glitch = 1'b1; step(1);
    gmod = 0;
    clr_glitch = 1'b0;
    check("clr.gcnt", glitch_cnt, 0);
    // Shortest glitch: single differing sample
    d_in = 1'b1; step(1);
    d_in = 1'b0; step(1);
    gmod = gsat(gmod);
    check("gl_short.gcnt", glitch_cnt, gexp());
    check_out("gl_short", 0, 0, 0);

    // Bypass: follow input each edge, alternating pulses, counter holds
    filter_en = 1'b0;
    for (int k = 0; k < 6; k++) begin
      d_in = ~d_in;
      step(1);
      check_out("byp", d_in, d_in, !d_in);
    end
    check("byp.gcnt", glitch_cnt, gexp());

    // Drop filter_en mid-qualify: immediate take, no glitch counted
    filter_en = 1'b1; d_in = 1'b0; step(1);
    check_out("pre_abort", 0, 0, 0);
    d_in = 1'b1; step(2);
    check_out("qual2", 0, 0, 0);
    filter_en = 1'b0; step(1);
    check_out("abort", 1, 1, 0);
    check("abort.gcnt", glitch_cnt, gexp());
    // Re-enable: starts STABLE with current level
    filter_en = 1'b1; step(1);
    check_out("reen", 1, 0, 0);
    d_in = 1'b0; step(1);
    d_in = 1'b1; step(1);
    gmod = gsat(gmod);
    check("reen.gcnt", glitch_cnt, gexp());
    check_out("reen2", 1, 0, 0);

    // Async reset mid-qualify: immediate return to reset state
    d_in = 1'b0; step(2);
    reset_n = 1'b0;
    #1;
    check_out("arst", 0, 0, 0);
    check("arst.gcnt", glitch_cnt, 0);
    step(1);
    reset_n = 1'b1;
    step(4);
    check_out("arst_rel", 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
